// File: rtl/dcache_port_arb.sv
// -----------------------------------------------------------------------------
// dcache_port_arb
//
// Purpose:
//   Shares the single Dcache request port between the load-issue path and the
//   retired-store drain path of the load/store queue. Loads win by default;
//   stores win while drain mode is active (store-queue occupancy hysteresis)
//   or once a pending store has lost STARVE_LIMIT consecutive cycles. The
//   winning request is registered and held stable until the Dcache acks it.
//   An MSHR stall suppresses the request, and a branch squash can withdraw an
//   in-flight load that has not been acknowledged yet.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   ld_req_i/ld_addr_i load request and address
//   ld_kill_i          squash of the pending or in-flight load
//   st_req_i/st_addr_i/st_data_i  retired store at SQ head
//   sq_cnt_i           store-queue occupancy (drives drain mode)
//   dc_stall_i         Dcache MSHR full
//   dc_ack_i           Dcache accepted the presented request
//   dc_req_o/dc_we_o/dc_addr_o/dc_data_o  request to the Dcache
//   ld_gnt_o/st_gnt_o  requester accepted this cycle
//   arb_state_o        0 IDLE, 1 LD_BUSY, 2 ST_BUSY
//   drain_mode_o       drain mode active
//   perf_*_cnt_o       performance counters
//
// Configuration:
//   DCACHE_ARB_PERF_CNT_EN  when defined, the three perf counters are live
//                           32-bit wrapping counters; otherwise they read 0.
// -----------------------------------------------------------------------------
module dcache_port_arb #(
  parameter int ADDR_W       = 64,
  parameter int SQ_CNT_W     = 4,
  parameter int DRAIN_HI     = 6,
  parameter int DRAIN_LO     = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_req_i,
  input  logic [ADDR_W-1:0]   ld_addr_i,
  input  logic                ld_kill_i,
  input  logic                st_req_i,
  input  logic [ADDR_W-1:0]   st_addr_i,
  input  logic [63:0]         st_data_i,
  input  logic [SQ_CNT_W-1:0] sq_cnt_i,
  input  logic                dc_stall_i,
  input  logic                dc_ack_i,
  output logic                dc_req_o,
  output logic                dc_we_o,
  output logic [ADDR_W-1:0]   dc_addr_o,
  output logic [63:0]         dc_data_o,
  output logic                ld_gnt_o,
  output logic                st_gnt_o,
  output logic [1:0]          arb_state_o,
  output logic                drain_mode_o,
  output logic [31:0]         perf_ld_cnt_o,
  output logic [31:0]         perf_st_cnt_o,
  output logic [31:0]         perf_stall_cnt_o
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);
  localparam logic [SQ_CNT_W-1:0] SQ_HI      = SQ_CNT_W'(DRAIN_HI);
  localparam logic [SQ_CNT_W-1:0] SQ_LO      = SQ_CNT_W'(DRAIN_LO);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_BUSY = 2'd1,
    ST_BUSY = 2'd2
  } arb_state_e;

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [63:0]         r_data;
  logic [63:0]         w_data_nxt;
  logic                r_drain;
  logic                w_drain_nxt;
  logic [STARVE_W-1:0] r_starve;
  logic [STARVE_W-1:0] w_starve_nxt;

  logic w_busy;
  logic w_req;
  logic w_ack;
  logic w_ld_gnt;
  logic w_st_gnt;
  logic w_arb_en;
  logic w_ld_elig;
  logic w_st_elig;
  logic w_st_first;

  // An ack only counts while a request is actually presented.
  assign w_busy   = (r_state != IDLE);
  assign w_req    = w_busy & ~dc_stall_i;
  assign w_ack    = dc_ack_i & w_req;
  assign w_ld_gnt = w_ack & (r_state == LD_BUSY);
  assign w_st_gnt = w_ack & (r_state == ST_BUSY);

  // Re-arbitrate from IDLE or in the ack cycle, so a waiting requester is
  // presented on the very next cycle. The requester being granted right now
  // is masked so the same request cannot issue twice.
  assign w_arb_en   = ~dc_stall_i & ((r_state == IDLE) | w_ack);
  assign w_ld_elig  = ld_req_i & ~ld_kill_i & ~w_ld_gnt;
  assign w_st_elig  = st_req_i & ~w_st_gnt;
  assign w_st_first = r_drain | (r_starve == STARVE_MAX);

  // Next-state and request-latch selection.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    if (w_arb_en) begin
      if (w_st_elig && (w_st_first || !w_ld_elig)) begin
        w_state_nxt = ST_BUSY;
        w_addr_nxt  = st_addr_i;
        w_data_nxt  = st_data_i;
      end else if (w_ld_elig) begin
        w_state_nxt = LD_BUSY;
        w_addr_nxt  = ld_addr_i;
        w_data_nxt  = 64'd0;
      end else begin
        w_state_nxt = IDLE;
      end
    end else if ((r_state == LD_BUSY) && ld_kill_i) begin
      // Squashed before the ack: drop it, keep the stale request registers.
      w_state_nxt = IDLE;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Drain-mode hysteresis and store starvation counter.
  always_comb begin
    w_drain_nxt  = r_drain;
    w_starve_nxt = r_starve;
    if (sq_cnt_i >= SQ_HI) begin
      w_drain_nxt = 1'b1;
    end else if (sq_cnt_i <= SQ_LO) begin
      w_drain_nxt = 1'b0;
    end else begin
      w_drain_nxt = r_drain;
    end
    if (w_st_gnt || !st_req_i) begin
      w_starve_nxt = {STARVE_W{1'b0}};
    end else if (r_starve != STARVE_MAX) begin
      w_starve_nxt = r_starve + STARVE_ONE;
    end else begin
      w_starve_nxt = r_starve;
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request, drain-mode and starvation registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= {ADDR_W{1'b0}};
      r_data   <= 64'd0;
      r_drain  <= 1'b0;
      r_starve <= {STARVE_W{1'b0}};
    end else begin
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
      r_drain  <= w_drain_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  assign dc_req_o     = w_req;
  assign dc_we_o      = (r_state == ST_BUSY);
  assign dc_addr_o    = r_addr;
  assign dc_data_o    = r_data;
  assign ld_gnt_o     = w_ld_gnt;
  assign st_gnt_o     = w_st_gnt;
  assign arb_state_o  = r_state;
  assign drain_mode_o = r_drain;

`ifdef DCACHE_ARB_PERF_CNT_EN
  logic [31:0] r_perf_ld;
  logic [31:0] r_perf_st;
  logic [31:0] r_perf_stall;

  // Wrapping grant and stall counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_ld    <= 32'd0;
      r_perf_st    <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      if (w_ld_gnt) begin
        r_perf_ld <= r_perf_ld + 32'd1;
      end
      if (w_st_gnt) begin
        r_perf_st <= r_perf_st + 32'd1;
      end
      if (w_busy && dc_stall_i) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_ld_cnt_o    = r_perf_ld;
  assign perf_st_cnt_o    = r_perf_st;
  assign perf_stall_cnt_o = r_perf_stall;
`else
  assign perf_ld_cnt_o    = 32'd0;
  assign perf_st_cnt_o    = 32'd0;
  assign perf_stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_port_arb.sv
module tb_dcache_port_arb;

  logic        clk;
  logic        rst_n;
  logic        ld_req_i;
  logic [63:0] ld_addr_i;
  logic        ld_kill_i;
  logic        st_req_i;
  logic [63:0] st_addr_i;
  logic [63:0] st_data_i;
  logic [3:0]  sq_cnt_i;
  logic        dc_stall_i;
  logic        dc_ack_i;
  logic        dc_req_o;
  logic        dc_we_o;
  logic [63:0] dc_addr_o;
  logic [63:0] dc_data_o;
  logic        ld_gnt_o;
  logic        st_gnt_o;
  logic [1:0]  arb_state_o;
  logic        drain_mode_o;
  logic [31:0] perf_ld_cnt_o;
  logic [31:0] perf_st_cnt_o;
  logic [31:0] perf_stall_cnt_o;

  dcache_port_arb dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ld_req_i         (ld_req_i),
    .ld_addr_i        (ld_addr_i),
    .ld_kill_i        (ld_kill_i),
    .st_req_i         (st_req_i),
    .st_addr_i        (st_addr_i),
    .st_data_i        (st_data_i),
    .sq_cnt_i         (sq_cnt_i),
    .dc_stall_i       (dc_stall_i),
    .dc_ack_i         (dc_ack_i),
    .dc_req_o         (dc_req_o),
    .dc_we_o          (dc_we_o),
    .dc_addr_o        (dc_addr_o),
    .dc_data_o        (dc_data_o),
    .ld_gnt_o         (ld_gnt_o),
    .st_gnt_o         (st_gnt_o),
    .arb_state_o      (arb_state_o),
    .drain_mode_o     (drain_mode_o),
    .perf_ld_cnt_o    (perf_ld_cnt_o),
    .perf_st_cnt_o    (perf_st_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
  );

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] data;
  } txn_t;

  txn_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic we, input logic [63:0] a, input logic [63:0] d);
    txn_t t;
    t.we   = we;
    t.addr = a;
    t.data = d;
    exp_q.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every grant must match the oldest expected request.
  always @(negedge clk) begin
    if (rst_n && (ld_gnt_o || st_gnt_o)) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_grant: ld_gnt=%0b st_gnt=%0b with nothing expected at %0t",
                 ld_gnt_o, st_gnt_o, $time);
      end else begin
        txn_t t;
        t = exp_q.pop_front();
        chk("grant_kind", {63'd0, st_gnt_o}, {63'd0, t.we});
        chk("grant_we",   {63'd0, dc_we_o},  {63'd0, t.we});
        chk("grant_addr", dc_addr_o, t.addr);
        chk("grant_data", dc_data_o, t.data);
      end
    end
  end

  task automatic chk_perf(input logic [31:0] e_ld, input logic [31:0] e_st, input logic [31:0] e_stall);
    chk("perf_ld",    {32'd0, perf_ld_cnt_o},    {32'd0, e_ld});
    chk("perf_st",    {32'd0, perf_st_cnt_o},    {32'd0, e_st});
    chk("perf_stall", {32'd0, perf_stall_cnt_o}, {32'd0, e_stall});
  endtask

  initial begin
    rst_n = 1'b0; ld_req_i = 1'b0; ld_addr_i = 64'd0; ld_kill_i = 1'b0;
    st_req_i = 1'b0; st_addr_i = 64'd0; st_data_i = 64'd0; sq_cnt_i = 4'd0;
    dc_stall_i = 1'b0; dc_ack_i = 1'b0;

    // Reset values
    #3;
    chk("rst_req",   {63'd0, dc_req_o},     64'd0);
    chk("rst_we",    {63'd0, dc_we_o},      64'd0);
    chk("rst_state", {62'd0, arb_state_o},  64'd0);
    chk("rst_drain", {63'd0, drain_mode_o}, 64'd0);
    chk("rst_addr",  dc_addr_o, 64'd0);
    chk("rst_data",  dc_data_o, 64'd0);
    chk_perf(32'd0, 32'd0, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Load held across 3 stall cycles, then acked once
    ld_req_i = 1'b1; ld_addr_i = 64'h100; push_exp(1'b0, 64'h100, 64'd0);
    step();
    ld_req_i = 1'b0; dc_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("stall_req",   {63'd0, dc_req_o},    64'd0);
      chk("stall_addr",  dc_addr_o,            64'h100);
      chk("stall_state", {62'd0, arb_state_o}, 64'd1);
      step();
    end
    dc_stall_i = 1'b0; dc_ack_i = 1'b1;
    #2 chk("unstall_req", {63'd0, dc_req_o}, 64'd1);
    step();
    dc_ack_i = 1'b0;
    #2 chk("after_ld_idle", {62'd0, arb_state_o}, 64'd0);

    // Kill without ack: no grant, IDLE, registers untouched
    step();
    ld_req_i = 1'b1; ld_addr_i = 64'h200;
    step();
    ld_req_i = 1'b0; ld_kill_i = 1'b1;
    #2 chk("kill_no_gnt", {63'd0, ld_gnt_o}, 64'd0);
    step();
    ld_kill_i = 1'b0;
    #2;
    chk("kill_idle", {62'd0, arb_state_o}, 64'd0);
    chk("kill_addr_hold", dc_addr_o, 64'h200);

    // Kill with ack in the same cycle: ack wins
    step();
    ld_req_i = 1'b1; ld_addr_i = 64'h300; push_exp(1'b0, 64'h300, 64'd0);
    step();
    ld_req_i = 1'b0; ld_kill_i = 1'b1; dc_ack_i = 1'b1;
    #2 chk("kill_ack_gnt", {63'd0, ld_gnt_o}, 64'd1);
    step();
    ld_kill_i = 1'b0; dc_ack_i = 1'b0;
    #2 chk("kill_ack_idle", {62'd0, arb_state_o}, 64'd0);

    // Back-to-back alternation with ack every cycle
    step();
    ld_req_i = 1'b1; ld_addr_i = 64'h400;
    st_req_i = 1'b1; st_addr_i = 64'h500; st_data_i = 64'hDEAD;
    push_exp(1'b0, 64'h400, 64'd0);
    step();
    dc_ack_i = 1'b1; ld_addr_i = 64'h404; push_exp(1'b1, 64'h500, 64'hDEAD);
    #2 chk("b2b_req0", {63'd0, dc_req_o}, 64'd1);
    chk("b2b_we0", {63'd0, dc_we_o}, 64'd0);
    step();
    st_addr_i = 64'h508; st_data_i = 64'hBEEF; push_exp(1'b0, 64'h404, 64'd0);
    #2 chk("b2b_req1", {63'd0, dc_req_o}, 64'd1);
    chk("b2b_we1", {63'd0, dc_we_o}, 64'd1);
    step();
    ld_req_i = 1'b0; push_exp(1'b1, 64'h508, 64'hBEEF);
    #2 chk("b2b_req2", {63'd0, dc_req_o}, 64'd1);
    chk("b2b_we2", {63'd0, dc_we_o}, 64'd0);
    step();
    st_req_i = 1'b0;
    #2 chk("b2b_we3", {63'd0, dc_we_o}, 64'd1);
    step();
    dc_ack_i = 1'b0;
    #2 chk("b2b_idle", {62'd0, arb_state_o}, 64'd0);

    // Drain-mode hysteresis and store priority
    for (int v = 0; v <= 6; v++) begin
      sq_cnt_i = 4'(v);
      step();
      #2 chk("drain_ramp", {63'd0, drain_mode_o}, (v == 6) ? 64'd1 : 64'd0);
    end
    ld_req_i = 1'b1; ld_addr_i = 64'h600;
    st_req_i = 1'b1; st_addr_i = 64'h700; st_data_i = 64'h77;
    push_exp(1'b1, 64'h700, 64'h77);
    step();
    dc_ack_i = 1'b1; st_req_i = 1'b0; push_exp(1'b0, 64'h600, 64'd0);
    #2 chk("drain_st_first", {63'd0, dc_we_o}, 64'd1);
    step();
    ld_req_i = 1'b0;
    #2 chk("drain_ld_next", {63'd0, dc_we_o}, 64'd0);
    step();
    dc_ack_i = 1'b0; sq_cnt_i = 4'd3;
    step();
    #2 chk("drain_hold3", {63'd0, drain_mode_o}, 64'd1);
    sq_cnt_i = 4'd2;
    step();
    #2 chk("drain_clr2", {63'd0, drain_mode_o}, 64'd0);
    sq_cnt_i = 4'd0;

    // Starvation: starve count 7 -> load wins, 8 -> store forced
    for (int s = 5; s <= 6; s++) begin
      step();
      ld_req_i = 1'b1; ld_addr_i = 64'h900;
      st_req_i = 1'b1; st_addr_i = 64'h800; st_data_i = 64'h88;
      step();
      ld_req_i = 1'b0; dc_stall_i = 1'b1;
      repeat (s) step();
      dc_stall_i = 1'b0; ld_kill_i = 1'b1;
      step();
      ld_kill_i = 1'b0;
      #2 chk("starve_kill_idle", {62'd0, arb_state_o}, 64'd0);
      ld_req_i = 1'b1; ld_addr_i = 64'h904;
      if (s == 6) push_exp(1'b1, 64'h800, 64'h88);
      else        push_exp(1'b0, 64'h904, 64'd0);
      step();
      ld_req_i = 1'b0; st_req_i = 1'b0; dc_ack_i = 1'b1;
      #2 chk("starve_winner", {63'd0, dc_we_o}, (s == 6) ? 64'd1 : 64'd0);
      step();
      dc_ack_i = 1'b0;
      #2 chk("starve_idle", {62'd0, arb_state_o}, 64'd0);
    end

`ifdef DCACHE_ARB_PERF_CNT_EN
    chk_perf(32'd6, 32'd4, 32'd14);
`else
    chk_perf(32'd0, 32'd0, 32'd0);
`endif

    // Asynchronous reset in the middle of ST_BUSY
    step();
    st_req_i = 1'b1; st_addr_i = 64'hA00; st_data_i = 64'hAA;
    step();
    st_req_i = 1'b0;
    #2 chk("pre_rst_state", {62'd0, arb_state_o}, 64'd2);
    rst_n = 1'b0; dc_ack_i = 1'b1;
    #1;
    chk("mid_rst_req",   {63'd0, dc_req_o},    64'd0);
    chk("mid_rst_stgnt", {63'd0, st_gnt_o},    64'd0);
    chk("mid_rst_state", {62'd0, arb_state_o}, 64'd0);
    chk("mid_rst_addr",  dc_addr_o, 64'd0);
    chk_perf(32'd0, 32'd0, 32'd0);
    step(); step();
    dc_ack_i = 1'b0; rst_n = 1'b1;
    step();
    #2;
    chk("post_rst_state", {62'd0, arb_state_o}, 64'd0);
    chk_perf(32'd0, 32'd0, 32'd0);
    step();
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
